// File: rtl/dram_arbiter.sv
// Two-port arbiter in front of a single-port 1024x32 byte-enable DRAM (port 0 = LSU, port 1 = loader).
// Default build: fixed priority to port 0 with a starvation guard; define DRAM_ARB_RR_EN for round-robin.
module dram_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = 4,
   parameter int MAX_WAIT   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  p0_req_valid,
   output logic                  p0_req_ready,
   input  logic                  p0_req_we,
   input  logic [BE_WIDTH-1:0]   p0_req_be,
   input  logic [ADDR_WIDTH-1:0] p0_req_addr,
   input  logic [DATA_WIDTH-1:0] p0_req_wdata,
   output logic                  p0_rsp_valid,
   output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
   input  logic                  p1_req_valid,
   output logic                  p1_req_ready,
   input  logic                  p1_req_we,
   input  logic [BE_WIDTH-1:0]   p1_req_be,
   input  logic [ADDR_WIDTH-1:0] p1_req_addr,
   input  logic [DATA_WIDTH-1:0] p1_req_wdata,
   output logic                  p1_rsp_valid,
   output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic                  ram_wr_en,
   output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  ram_rst
);

   logic gnt0, gnt1, any_gnt;
   logic rsp_pend_q, rsp_pend_d;
   logic rsp_owner_q, rsp_owner_d;
   logic rsp_is_wr_q, rsp_is_wr_d;

`ifdef DRAM_ARB_RR_EN
   logic last_gnt_q, last_gnt_d;

   // On contention the port that did not win last time goes first.
   always_comb begin
      gnt1       = p1_req_valid & (~p0_req_valid | ~last_gnt_q);
      last_gnt_d = any_gnt ? p1_req_ready : last_gnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) last_gnt_q <= 1'b0;
      else        last_gnt_q <= last_gnt_d;
   end
`else
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       force1;

   always_comb begin
      force1     = (wait_cnt_q == 8'(MAX_WAIT));
      gnt1       = p1_req_valid & (~p0_req_valid | force1);
      wait_cnt_d = wait_cnt_q;
      if (!p1_req_valid || gnt1)
         wait_cnt_d = 8'd0;
      else if (wait_cnt_q < 8'(MAX_WAIT))
         wait_cnt_d = wait_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) wait_cnt_q <= 8'd0;
      else        wait_cnt_q <= wait_cnt_d;
   end
`endif

   always_comb begin
      gnt0         = p0_req_valid & ~gnt1;
      p0_req_ready = gnt0 & rst_n;
      p1_req_ready = gnt1 & rst_n;
      any_gnt      = p0_req_ready | p1_req_ready;
      ram_rst      = ~rst_n;
   end

   // RAM is driven to idle whenever nothing is granted, including during reset.
   always_comb begin
      ram_addr       = '0;
      ram_wr_data    = '0;
      ram_wr_en      = 1'b0;
      ram_wr_byte_en = '0;
      if (p1_req_ready) begin
         ram_addr       = p1_req_addr;
         ram_wr_data    = p1_req_wdata;
         ram_wr_en      = p1_req_we;
         ram_wr_byte_en = p1_req_we ? p1_req_be : '0;
      end else if (p0_req_ready) begin
         ram_addr       = p0_req_addr;
         ram_wr_data    = p0_req_wdata;
         ram_wr_en      = p0_req_we;
         ram_wr_byte_en = p0_req_we ? p0_req_be : '0;
      end
   end

   always_comb begin
      rsp_pend_d  = any_gnt;
      rsp_owner_d = p1_req_ready;
      rsp_is_wr_d = p1_req_ready ? p1_req_we : (p0_req_ready & p0_req_we);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_pend_q  <= 1'b0;
         rsp_owner_q <= 1'b0;
         rsp_is_wr_q <= 1'b0;
      end else begin
         rsp_pend_q  <= rsp_pend_d;
         rsp_owner_q <= rsp_owner_d;
         rsp_is_wr_q <= rsp_is_wr_d;
      end
   end

   // Gating with rst_n drops a response whose delivery cycle coincides with reset.
   always_comb begin
      p0_rsp_valid = rsp_pend_q & ~rsp_owner_q & rst_n;
      p1_rsp_valid = rsp_pend_q &  rsp_owner_q & rst_n;
      p0_rsp_rdata = (p0_rsp_valid & ~rsp_is_wr_q) ? ram_rd_data : '0;
      p1_rsp_rdata = (p1_rsp_valid & ~rsp_is_wr_q) ? ram_rd_data : '0;
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural byte-enable RAM attached to the RAM side.
module tb_dram_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_req_valid, p0_req_ready, p0_req_we;
   logic [3:0]  p0_req_be;
   logic [9:0]  p0_req_addr;
   logic [31:0] p0_req_wdata;
   logic        p0_rsp_valid;
   logic [31:0] p0_rsp_rdata;
   logic        p1_req_valid, p1_req_ready, p1_req_we;
   logic [3:0]  p1_req_be;
   logic [9:0]  p1_req_addr;
   logic [31:0] p1_req_wdata;
   logic        p1_rsp_valid;
   logic [31:0] p1_rsp_rdata;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wr_data;
   logic        ram_wr_en;
   logic [3:0]  ram_wr_byte_en;
   logic [31:0] ram_rd_data;
   logic        ram_rst;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [1024];

   always #5 clk = ~clk;

   dram_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BE_WIDTH(4), .MAX_WAIT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
      .p0_req_be(p0_req_be), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
      .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
      .p1_req_be(p1_req_be), .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
      .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
      .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
      .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_data(ram_rd_data), .ram_rst(ram_rst)
   );

   // Single-port RAM: write commits at the edge, read data appears the cycle after the address.
   always @(posedge clk) begin
      if (ram_wr_en) begin
         for (int b = 0; b < 4; b++)
            if (ram_wr_byte_en[b]) mem[ram_addr][b*8 +: 8] = ram_wr_data[b*8 +: 8];
      end
      ram_rd_data <= mem[ram_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      p0_req_valid = 0; p0_req_we = 0; p0_req_be = 0; p0_req_addr = 0; p0_req_wdata = 0;
      p1_req_valid = 0; p1_req_we = 0; p1_req_be = 0; p1_req_addr = 0; p1_req_wdata = 0;
   endtask

   task automatic do_reset();
      rst_n = 0; idle();
      tick(); tick();
      rst_n = 1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      p0_req_valid = 1; p0_req_we = 1; p0_req_be = 4'hF; p0_req_addr = 10'h055; p0_req_wdata = 32'h1111_2222;
      p1_req_valid = 1; p1_req_addr = 10'h066;
      tick(); tick();
      checks++; if (p0_req_ready !== 1'b0) begin errors++; $display("FAIL rst_p0_ready got %b want 0", p0_req_ready); end
      checks++; if (p1_req_ready !== 1'b0) begin errors++; $display("FAIL rst_p1_ready got %b want 0", p1_req_ready); end
      checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", ram_wr_en); end
      checks++; if (ram_wr_byte_en !== 4'h0) begin errors++; $display("FAIL rst_be got %h want 0", ram_wr_byte_en); end
      checks++; if (ram_addr !== 10'h000) begin errors++; $display("FAIL rst_addr got %h want 000", ram_addr); end
      checks++; if (ram_rst !== 1'b1) begin errors++; $display("FAIL rst_ram_rst got %b want 1", ram_rst); end
      checks++; if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b want 00", {p0_rsp_valid, p1_rsp_valid}); end
      idle();
      rst_n = 1;
      #1;
      checks++; if (ram_rst !== 1'b0) begin errors++; $display("FAIL rst_ram_rst_release got %b want 0", ram_rst); end
   endtask

   task automatic test_p0_read();
      p0_req_valid = 1; p0_req_we = 0; p0_req_addr = 10'h005;
      #1;
      checks++; if (p0_req_ready !== 1'b1) begin errors++; $display("FAIL p0rd_ready got %b want 1", p0_req_ready); end
      checks++; if (ram_addr !== 10'h005) begin errors++; $display("FAIL p0rd_addr got %h want 005", ram_addr); end
      checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL p0rd_wr_en got %b want 0", ram_wr_en); end
      tick();
      idle();
      #1;
      checks++; if (p0_rsp_valid !== 1'b1) begin errors++; $display("FAIL p0rd_rsp_valid got %b want 1", p0_rsp_valid); end
      checks++; if (p0_rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL p0rd_rdata got %h want deadbeef", p0_rsp_rdata); end
      checks++; if (p1_rsp_valid !== 1'b0) begin errors++; $display("FAIL p0rd_p1_valid got %b want 0", p1_rsp_valid); end
      checks++; if (p1_rsp_rdata !== 32'h0) begin errors++; $display("FAIL p0rd_p1_rdata got %h want 0", p1_rsp_rdata); end
      tick();
      checks++; if (p0_rsp_valid !== 1'b0) begin errors++; $display("FAIL p0rd_one_pulse got %b want 0", p0_rsp_valid); end
   endtask

   task automatic test_p1_write_read();
      p1_req_valid = 1; p1_req_we = 1; p1_req_be = 4'b0011; p1_req_addr = 10'h3FF; p1_req_wdata = 32'h12345678;
      #1;
      checks++; if (p1_req_ready !== 1'b1) begin errors++; $display("FAIL p1wr_ready got %b want 1", p1_req_ready); end
      checks++; if (ram_wr_en !== 1'b1) begin errors++; $display("FAIL p1wr_wr_en got %b want 1", ram_wr_en); end
      checks++; if (ram_wr_byte_en !== 4'b0011) begin errors++; $display("FAIL p1wr_be got %b want 0011", ram_wr_byte_en); end
      tick();
      p1_req_we = 0; p1_req_be = 0; p1_req_wdata = 0;
      #1;
      checks++; if (p1_rsp_valid !== 1'b1) begin errors++; $display("FAIL p1wr_ack got %b want 1", p1_rsp_valid); end
      checks++; if (p1_rsp_rdata !== 32'h0) begin errors++; $display("FAIL p1wr_ack_rdata got %h want 0", p1_rsp_rdata); end
      tick();
      idle();
      #1;
      checks++; if (p1_rsp_valid !== 1'b1) begin errors++; $display("FAIL p1rd_valid got %b want 1", p1_rsp_valid); end
      checks++; if (p1_rsp_rdata !== 32'h00005678) begin errors++; $display("FAIL p1rd_rdata got %h want 00005678", p1_rsp_rdata); end
      checks++; if (p0_rsp_valid !== 1'b0) begin errors++; $display("FAIL p1rd_p0_valid got %b want 0", p0_rsp_valid); end
      tick();
   endtask

   task automatic test_arbitration();
      logic exp1;
      do_reset();
      p0_req_valid = 1; p0_req_addr = 10'h005;
      p1_req_valid = 1; p1_req_addr = 10'h3FF;
      for (int i = 0; i < 20; i++) begin
`ifdef DRAM_ARB_RR_EN
         exp1 = (i % 2 == 0);
`else
         exp1 = (i == 8) || (i == 17);
`endif
         #1;
         checks++; if (p1_req_ready !== exp1) begin errors++; $display("FAIL arb_p1_ready cyc %0d got %b want %b", i, p1_req_ready, exp1); end
         checks++; if (p0_req_ready !== !exp1) begin errors++; $display("FAIL arb_p0_ready cyc %0d got %b want %b", i, p0_req_ready, !exp1); end
         tick();
         checks++; if (p1_rsp_valid !== exp1) begin errors++; $display("FAIL arb_p1_rsp cyc %0d got %b want %b", i, p1_rsp_valid, exp1); end
         checks++; if (p0_rsp_rdata !== (exp1 ? 32'h0 : 32'hDEADBEEF)) begin errors++; $display("FAIL arb_p0_rdata cyc %0d got %h", i, p0_rsp_rdata); end
      end
      idle();
      tick();
   endtask

   task automatic test_wr_then_rd();
      p0_req_valid = 1; p0_req_we = 1; p0_req_be = 4'hF; p0_req_addr = 10'h010; p0_req_wdata = 32'hA5A5A5A5;
      tick();
      idle();
      p1_req_valid = 1; p1_req_addr = 10'h010;
      #1;
      checks++; if (p1_req_ready !== 1'b1) begin errors++; $display("FAIL wrrd_p1_ready got %b want 1", p1_req_ready); end
      checks++; if (p0_rsp_valid !== 1'b1) begin errors++; $display("FAIL wrrd_p0_ack got %b want 1", p0_rsp_valid); end
      tick();
      idle();
      #1;
      checks++; if (p1_rsp_valid !== 1'b1) begin errors++; $display("FAIL wrrd_p1_valid got %b want 1", p1_rsp_valid); end
      checks++; if (p1_rsp_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrrd_p1_rdata got %h want a5a5a5a5", p1_rsp_rdata); end
      tick();
   endtask

   task automatic test_back_to_back();
      p0_req_valid = 1; p0_req_addr = 10'h005;
      tick();
      p0_req_addr = 10'h010;
      #1;
      checks++; if (p0_rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_first got %h want deadbeef", p0_rsp_rdata); end
      tick();
      idle();
      #1;
      checks++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_second got %b/%h want 1/a5a5a5a5", p0_rsp_valid, p0_rsp_rdata); end
      tick();
   endtask

   task automatic test_reset_drop();
      p0_req_valid = 1; p0_req_addr = 10'h005;
      tick();
      rst_n = 0;
      p0_req_we = 1; p0_req_be = 4'hF; p0_req_wdata = 32'hFFFF_FFFF;
      #1;
      checks++; if (p0_rsp_valid !== 1'b0) begin errors++; $display("FAIL rdrop_valid got %b want 0", p0_rsp_valid); end
      checks++; if (p0_req_ready !== 1'b0 || ram_wr_en !== 1'b0) begin errors++; $display("FAIL rdrop_ready_wr got %b/%b want 0/0", p0_req_ready, ram_wr_en); end
      tick();
      checks++; if (p0_rsp_valid !== 1'b0 || p0_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rdrop_after got %b/%h want 0/0", p0_rsp_valid, p0_rsp_rdata); end
      rst_n = 1;
      p0_req_we = 0; p0_req_be = 0; p0_req_wdata = 0;
      #1;
      checks++; if (p0_req_ready !== 1'b1) begin errors++; $display("FAIL rdrop_resume_ready got %b want 1", p0_req_ready); end
      checks++; if (p0_rsp_valid !== 1'b0) begin errors++; $display("FAIL rdrop_no_late_rsp got %b want 0", p0_rsp_valid); end
      tick();
      idle();
      #1;
      checks++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdrop_resume_rsp got %b/%h want 1/deadbeef", p0_rsp_valid, p0_rsp_rdata); end
      tick();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[10'h005] = 32'hDEADBEEF;
      rst_n = 0;
      idle();
      test_reset();
      test_p0_read();
      test_p1_write_read();
      test_arbitration();
      test_wr_then_rd();
      test_back_to_back();
      test_reset_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
